// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the multi-channel alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

  localparam int TIME_W = 24;
  localparam int HHMM_W = 16;
  localparam int SEC_W  = 8;
  localparam int DAYS_W = 7;
  localparam int WDAY_W = 3;

  // Bits needed to hold max(a, b), never less than one.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: config registers, match detect, ring/snooze FSM.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 5,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [WDAY_W-1:0] cur_wday,
  input  logic              wr_hit,
  input  logic [HHMM_W-1:0] wr_hhmm,
  input  logic [DAYS_W-1:0] wr_days,
  input  logic              wr_on,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              ringing,
  output logic              snoozing
);

  localparam int CW = cnt_w(RING_SEC, SNOOZE_SEC);
  localparam int SW = cnt_w(MAX_SNOOZE, 0);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SEC);
  localparam logic [CW-1:0] SNZ_LD  = CW'(SNOOZE_SEC);
  localparam logic [SW-1:0] SNZ_MAX = SW'(MAX_SNOOZE);

  alarm_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [HHMM_W-1:0] hhmm_q, hhmm_d;
  logic [DAYS_W-1:0] days_q, days_d;
  logic              on_q, on_d;
  logic              fired_q, fired_d;

  logic day_ok;
  logic hit;
  logic match;

  always_comb begin
    day_ok = (cur_wday != 3'd7) && days_q[cur_wday];
    hit = tick
       && (cur_time[SEC_W-1:0] == 8'h00)
       && (cur_time[TIME_W-1:SEC_W] == hhmm_q)
       && on_q && day_ok;
    // One trigger per minute: arm again once seconds leave :00.
    match = hit && !fired_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    hhmm_d  = hhmm_q;
    days_d  = days_q;
    on_d    = on_q;
    fired_d = fired_q;
    if (cur_time[SEC_W-1:0] != 8'h00) begin
      fired_d = 1'b0;
    end else if (hit) begin
      fired_d = 1'b1;
    end
    if (wr_hit) begin
      hhmm_d  = wr_hhmm;
      days_d  = wr_days;
      on_d    = wr_on;
      state_d = IDLE;
      scnt_d  = '0;
    end else if (dismiss) begin
      state_d = IDLE;
      scnt_d  = '0;
    end else if (snooze && state_q == RINGING) begin
      if (scnt_q < SNZ_MAX) begin
        scnt_d  = scnt_q + SW'(1);
        cnt_d   = SNZ_LD;
        state_d = SNOOZE;
      end else begin
        state_d = IDLE;
      end
    end else if (match) begin
      state_d = RINGING;
      cnt_d   = RING_LD;
      scnt_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        RINGING: begin
          if (cnt_q == CW'(1)) state_d = IDLE;
          else cnt_d = cnt_q - CW'(1);
        end
        SNOOZE: begin
          if (cnt_q == CW'(1)) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
      hhmm_q  <= '0;
      days_q  <= '0;
      on_q    <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      hhmm_q  <= hhmm_d;
      days_q  <= days_d;
      on_q    <= on_d;
      fired_q <= fired_d;
    end
  end

  assign ringing  = (state_q == RINGING);
  assign snoozing = (state_q == SNOOZE);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-channel alarm controller: channel array plus registered buzzer,
// ring vector, lowest-ringing-channel encoder and snooze flag.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int RING_SEC   = 5,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int CHW       = idx_w(N_CH)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [WDAY_W-1:0] cur_wday,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [HHMM_W-1:0] wr_hhmm,
  input  logic [DAYS_W-1:0] wr_days,
  input  logic              wr_on,
  input  logic              snooze,
  input  logic              dismiss,
  output logic [N_CH-1:0]   ring_vec,
  output logic              buzzer,
  output logic [CHW-1:0]    ring_ch,
  output logic              snoozing
);

  logic [N_CH-1:0] ring_now;
  logic [N_CH-1:0] snz_now;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = wr_en && (wr_ch == CHW'(i));
    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_ch (
      .clk      (mclk),
      .rst_n    (rst),
      .tick     (tick_1hz),
      .cur_time (cur_time),
      .cur_wday (cur_wday),
      .wr_hit   (hit),
      .wr_hhmm  (wr_hhmm),
      .wr_days  (wr_days),
      .wr_on    (wr_on),
      .snooze   (snooze),
      .dismiss  (dismiss),
      .ringing  (ring_now[i]),
      .snoozing (snz_now[i])
    );
  end

  logic [N_CH-1:0] ring_vec_q;
  logic            buzzer_q;
  logic [CHW-1:0]  ring_ch_q, ring_ch_d;
  logic            snoozing_q;

  always_comb begin
    ring_ch_d = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ring_now[i]) ring_ch_d = CHW'(i);
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      ring_vec_q <= '0;
      buzzer_q   <= 1'b0;
      ring_ch_q  <= '0;
      snoozing_q <= 1'b0;
    end else begin
      ring_vec_q <= ring_now;
      buzzer_q   <= |ring_now;
      ring_ch_q  <= ring_ch_d;
      snoozing_q <= |snz_now;
    end
  end

  assign ring_vec = ring_vec_q;
  assign buzzer   = buzzer_q;
  assign ring_ch  = ring_ch_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed vector bench for multi_alarm_ctrl (N_CH=4, short timers).
module tb_multi_alarm_ctrl;

  logic        mclk;
  logic        rst;
  logic        tick_1hz;
  logic [23:0] cur_time;
  logic [2:0]  cur_wday;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_hhmm;
  logic [6:0]  wr_days;
  logic        wr_on;
  logic        snooze;
  logic        dismiss;
  logic [3:0]  ring_vec;
  logic        buzzer;
  logic [1:0]  ring_ch;
  logic        snoozing;

  int checks = 0;
  int failures = 0;

  multi_alarm_ctrl #(
    .N_CH       (4),
    .RING_SEC   (3),
    .SNOOZE_SEC (4),
    .MAX_SNOOZE (2)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .cur_time (cur_time),
    .cur_wday (cur_wday),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_hhmm  (wr_hhmm),
    .wr_days  (wr_days),
    .wr_on    (wr_on),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .ring_vec (ring_vec),
    .buzzer   (buzzer),
    .ring_ch  (ring_ch),
    .snoozing (snoozing)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // exp = {ring_vec, buzzer, ring_ch, snoozing}
  typedef struct packed {
    logic        wr;
    logic [1:0]  ch;
    logic [15:0] hhmm;
    logic [6:0]  days;
    logic        en;
    logic        tk;
    logic [23:0] tm;
    logic [2:0]  wd;
    logic        sz;
    logic        ds;
    logic [7:0]  exp;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  function automatic vec_t wv(
    input logic [1:0]  ch,
    input logic [15:0] hhmm,
    input logic [6:0]  days,
    input logic        en,
    input logic [23:0] tm,
    input logic [7:0]  exp
  );
    vec_t v;
    v = '0;
    v.wr = 1'b1;
    v.ch = ch;
    v.hhmm = hhmm;
    v.days = days;
    v.en = en;
    v.tm = tm;
    v.wd = 3'd3;
    v.exp = exp;
    return v;
  endfunction

  function automatic vec_t ev(
    input logic        tk,
    input logic [23:0] tm,
    input logic [2:0]  wd,
    input logic        sz,
    input logic        ds,
    input logic [7:0]  exp
  );
    vec_t v;
    v = '0;
    v.tk = tk;
    v.tm = tm;
    v.wd = wd;
    v.sz = sz;
    v.ds = ds;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] ex(
    input logic [3:0] rv,
    input logic       bz,
    input logic [1:0] rc,
    input logic       sn
  );
    return {rv, bz, rc, sn};
  endfunction

  task automatic clk1();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {ring_vec, buzzer, ring_ch, snoozing};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic clear_pulses();
    tick_1hz = 1'b0;
    wr_en = 1'b0;
    snooze = 1'b0;
    dismiss = 1'b0;
  endtask

  initial begin
    logic [7:0] z;
    logic [7:0] r0;
    logic [7:0] sn;
    z  = ex(4'b0000, 1'b0, 2'd0, 1'b0);
    r0 = ex(4'b0001, 1'b1, 2'd0, 1'b0);
    sn = ex(4'b0000, 1'b0, 2'd0, 1'b1);

    vecs[0]  = wv(2'd0, 16'h0730, 7'h7F, 1'b1, 24'h000000, z);
    vecs[1]  = ev(1'b1, 24'h073000, 3'd3, 1'b0, 1'b0, r0);
    vecs[2]  = ev(1'b1, 24'h073001, 3'd3, 1'b0, 1'b0, r0);
    vecs[3]  = ev(1'b1, 24'h073002, 3'd3, 1'b0, 1'b0, r0);
    vecs[4]  = ev(1'b1, 24'h073003, 3'd3, 1'b0, 1'b0, z);
    vecs[5]  = ev(1'b1, 24'h073000, 3'd3, 1'b0, 1'b0, r0);
    vecs[6]  = ev(1'b0, 24'h073000, 3'd3, 1'b1, 1'b0, sn);
    vecs[7]  = ev(1'b1, 24'h073001, 3'd3, 1'b0, 1'b0, sn);
    vecs[8]  = ev(1'b1, 24'h073002, 3'd3, 1'b0, 1'b0, sn);
    vecs[9]  = ev(1'b1, 24'h073003, 3'd3, 1'b0, 1'b0, sn);
    vecs[10] = ev(1'b1, 24'h073004, 3'd3, 1'b0, 1'b0, r0);
    vecs[11] = ev(1'b0, 24'h073004, 3'd3, 1'b1, 1'b0, sn);
    vecs[12] = ev(1'b1, 24'h073005, 3'd3, 1'b0, 1'b0, sn);
    vecs[13] = ev(1'b1, 24'h073006, 3'd3, 1'b0, 1'b0, sn);
    vecs[14] = ev(1'b1, 24'h073007, 3'd3, 1'b0, 1'b0, sn);
    vecs[15] = ev(1'b1, 24'h073008, 3'd3, 1'b0, 1'b0, r0);
    vecs[16] = ev(1'b0, 24'h073008, 3'd3, 1'b1, 1'b0, z);
    vecs[17] = ev(1'b1, 24'h073009, 3'd3, 1'b0, 1'b0, z);
    vecs[18] = wv(2'd1, 16'h0600, 7'h7F, 1'b1, 24'h055959, z);
    vecs[19] = wv(2'd2, 16'h0600, 7'h7F, 1'b1, 24'h055959, z);
    vecs[20] = ev(1'b1, 24'h060000, 3'd3, 1'b0, 1'b0,
                  ex(4'b0110, 1'b1, 2'd1, 1'b0));
    vecs[21] = ev(1'b0, 24'h060001, 3'd3, 1'b1, 1'b0, sn);
    vecs[22] = ev(1'b0, 24'h060001, 3'd3, 1'b1, 1'b1, z);
    vecs[23] = ev(1'b1, 24'h060000, 3'd3, 1'b0, 1'b0,
                  ex(4'b0110, 1'b1, 2'd1, 1'b0));
    vecs[24] = ev(1'b0, 24'h060000, 3'd3, 1'b1, 1'b1, z);
    vecs[25] = wv(2'd3, 16'h0815, 7'b0000010, 1'b1, 24'h081459, z);
    vecs[26] = ev(1'b1, 24'h081500, 3'd0, 1'b0, 1'b0, z);
    vecs[27] = ev(1'b1, 24'h081500, 3'd1, 1'b0, 1'b0,
                  ex(4'b1000, 1'b1, 2'd3, 1'b0));
    vecs[28] = ev(1'b0, 24'h081500, 3'd1, 1'b0, 1'b1, z);
    vecs[29] = ev(1'b0, 24'h081501, 3'd1, 1'b0, 1'b0, z);
    vecs[30] = ev(1'b1, 24'h081500, 3'd7, 1'b0, 1'b0, z);
    vecs[31] = ev(1'b1, 24'h073005, 3'd3, 1'b0, 1'b0, z);
    vecs[32] = ev(1'b1, 24'h073000, 3'd3, 1'b0, 1'b0, r0);
    vecs[33] = wv(2'd0, 16'h0730, 7'h7F, 1'b1, 24'h073000, z);
    vecs[34] = ev(1'b1, 24'h073000, 3'd3, 1'b0, 1'b0, z);

    rst = 1'b0;
    cur_time = '0;
    cur_wday = 3'd3;
    wr_ch = '0;
    wr_hhmm = '0;
    wr_days = '0;
    wr_on = 1'b0;
    clear_pulses();
    clk1();
    clk1();
    check("reset", z);
    rst = 1'b1;
    clk1();
    check("reset_release", z);

    for (int i = 0; i < NV; i++) begin
      wr_en    = vecs[i].wr;
      wr_ch    = vecs[i].ch;
      wr_hhmm  = vecs[i].hhmm;
      wr_days  = vecs[i].days;
      wr_on    = vecs[i].en;
      tick_1hz = vecs[i].tk;
      cur_time = vecs[i].tm;
      cur_wday = vecs[i].wd;
      snooze   = vecs[i].sz;
      dismiss  = vecs[i].ds;
      clk1();
      clear_pulses();
      clk1();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Output latency and asynchronous reset while ringing.
    cur_time = 24'h073001;
    cur_wday = 3'd3;
    clk1();
    cur_time = 24'h073000;
    tick_1hz = 1'b1;
    clk1();
    tick_1hz = 1'b0;
    check("latency_one_edge", z);
    clk1();
    check("ring_before_reset", r0);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", z);
    @(negedge mclk);
    rst = 1'b1;
    cur_time = 24'h073001;
    clk1();
    cur_time = 24'h073000;
    tick_1hz = 1'b1;
    clk1();
    tick_1hz = 1'b0;
    clk1();
    check("config_cleared", z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
